// File: rtl/lcd_pkg.sv
// Shared frame-buffer geometry and the arbiter's state encoding.
package lcd_pkg;
   localparam int LCD_PAGES  = 8;
   localparam int LCD_COLS   = 128;
   localparam int LCD_ADDR_W = $clog2(LCD_PAGES * LCD_COLS);
   localparam int LCD_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      CLEAR  = 2'd3
   } arb_state_t;
endpackage

// File: rtl/lcd_refresh_sched.sv
// Decides when the display controller should pull a fresh frame: the buffer
// must be dirty, writes must have been quiet for HOLDOFF cycles, and the LCD idle.
module lcd_refresh_sched #(
   parameter int HOLDOFF = 64
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic ram_we,
   input  logic arb_idle,
   input  logic lcd_busy,
   output logic refresh_start
);
   localparam logic [15:0] HOLD = 16'(HOLDOFF);

   logic        dirty_reg;
   logic        wait_busy_reg;
   logic [15:0] quiet_cnt_reg;
   logic        refresh_start_reg;
   logic        fire;

   // A write landing this cycle keeps the buffer dirty, so it also vetoes the pulse.
   assign fire = arb_idle && !ram_we && dirty_reg && (quiet_cnt_reg == HOLD)
                 && !lcd_busy && !wait_busy_reg;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dirty_reg         <= 1'b1;
         wait_busy_reg     <= 1'b0;
         quiet_cnt_reg     <= '0;
         refresh_start_reg <= 1'b0;
      end else begin
         refresh_start_reg <= fire;
         if (ram_we) begin
            dirty_reg     <= 1'b1;
            quiet_cnt_reg <= '0;
         end else begin
            if (fire)
               dirty_reg <= 1'b0;
            if (quiet_cnt_reg != HOLD)
               quiet_cnt_reg <= quiet_cnt_reg + 16'd1;
         end
         // Hold off until the controller has visibly picked up the pulse.
         if (fire)
            wait_busy_reg <= 1'b1;
         else if (lcd_busy)
            wait_busy_reg <= 1'b0;
      end
   end

   assign refresh_start = refresh_start_reg;
endmodule

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer write-port owner: round-robin between two pixel writers with a
// burst cap, a zero-fill clear engine, and refresh scheduling for the LCD.
module lcd_fb_arbiter
   import lcd_pkg::*;
#(
   parameter int ADDR_W    = LCD_ADDR_W,
   parameter int DATA_W    = LCD_DATA_W,
   parameter int MAX_BURST = 16,
   parameter int HOLDOFF   = 64
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              req0,
   input  logic              req1,
   output logic              gnt0,
   output logic              gnt1,
   input  logic              wr_valid0,
   input  logic              wr_valid1,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic              lcd_busy,
   output logic              refresh_start
);
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   arb_state_t        state_reg, state_next;
   logic [1:0]        req, wr_valid, accept;
   logic [1:0]        gnt_reg, gnt_next;
   logic              clear_busy_reg, clear_busy_next;
   logic              rr_ptr_reg;
   logic              clear_pend_reg;
   logic [7:0]        beat_cnt_reg;
   logic [ADDR_W-1:0] clear_addr_reg;
   logic              ram_we_reg, ram_we_next;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [DATA_W-1:0] ram_data_reg, ram_data_next;
   logic              burst_done, clear_last, arb_idle, grant_exit;

   assign req      = {req1, req0};
   assign wr_valid = {wr_valid1, wr_valid0};

   for (genvar gi = 0; gi < 2; gi++) begin : g_accept
      assign accept[gi] = gnt_reg[gi] & wr_valid[gi];
   end

   assign burst_done = (|accept) && (beat_cnt_reg == BURST_LAST);
   assign clear_last = &clear_addr_reg;
   assign grant_exit = ((state_reg == GRANT0) || (state_reg == GRANT1)) && (state_next == IDLE);

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (clear_pend_reg)
               state_next = CLEAR;
            else if (req[0] && req[1])
               state_next = rr_ptr_reg ? GRANT1 : GRANT0;
            else if (req[0])
               state_next = GRANT0;
            else if (req[1])
               state_next = GRANT1;
         end
         GRANT0:  if (!req[0] || burst_done) state_next = IDLE;
         GRANT1:  if (!req[1] || burst_done) state_next = IDLE;
         CLEAR:   if (clear_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grants follow the decided state, so every owner change passes through one IDLE cycle.
   always_comb begin
      gnt_next        = {state_next == GRANT1, state_next == GRANT0};
      clear_busy_next = (state_next == CLEAR);
      ram_we_next     = 1'b0;
      ram_addr_next   = ram_addr_reg;
      ram_data_next   = ram_data_reg;
      if (state_reg == CLEAR) begin
         ram_we_next   = 1'b1;
         ram_addr_next = clear_addr_reg;
         ram_data_next = '0;
      end else if (accept[0]) begin
         ram_we_next   = 1'b1;
         ram_addr_next = wr_addr0;
         ram_data_next = wr_data0;
      end else if (accept[1]) begin
         ram_we_next   = 1'b1;
         ram_addr_next = wr_addr1;
         ram_data_next = wr_data1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         gnt_reg        <= '0;
         clear_busy_reg <= 1'b0;
         ram_we_reg     <= 1'b0;
         ram_addr_reg   <= '0;
         ram_data_reg   <= '0;
         rr_ptr_reg     <= 1'b0;
         clear_pend_reg <= 1'b0;
         beat_cnt_reg   <= '0;
         clear_addr_reg <= '0;
      end else begin
         gnt_reg        <= gnt_next;
         clear_busy_reg <= clear_busy_next;
         ram_we_reg     <= ram_we_next;
         ram_addr_reg   <= ram_addr_next;
         ram_data_reg   <= ram_data_next;
         clear_addr_reg <= (state_reg == CLEAR) ? clear_addr_reg + 1'b1 : '0;
         if (grant_exit) begin
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= (state_reg == GRANT0);
         end else if (|accept) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
         end
         // Finishing a clear wins over a new request, so a late pulse never re-arms it.
         if ((state_reg == CLEAR) && clear_last)
            clear_pend_reg <= 1'b0;
         else if (clear_req)
            clear_pend_reg <= 1'b1;
      end
   end

   assign arb_idle = (state_reg == IDLE) && !req[0] && !req[1] && !clear_pend_reg && !clear_req;

   lcd_refresh_sched #(
      .HOLDOFF(HOLDOFF)
   ) u_refresh_sched (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .ram_we       (ram_we_reg),
      .arb_idle     (arb_idle),
      .lcd_busy     (lcd_busy),
      .refresh_start(refresh_start)
   );

   assign gnt0       = gnt_reg[0];
   assign gnt1       = gnt_reg[1];
   assign clear_busy = clear_busy_reg;
   assign ram_we     = ram_we_reg;
   assign ram_addr   = ram_addr_reg;
   assign ram_data   = ram_data_reg;
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed-sequence bench for lcd_fb_arbiter with random write payloads and an
// owner-schedule model built from burst/idle/clear segment lengths.
`timescale 1ns/1ps
module tb_lcd_fb_arbiter;
   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 16;
   localparam int HOLDOFF   = 64;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int K_NONE = 0, K_G0 = 1, K_G1 = 2, K_CLR = 3;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              req0 = 1'b0, req1 = 1'b0;
   logic              gnt0, gnt1;
   logic              wr_valid0 = 1'b0, wr_valid1 = 1'b0;
   logic [ADDR_W-1:0] wr_addr0 = '0, wr_addr1 = '0;
   logic [DATA_W-1:0] wr_data0 = '0, wr_data1 = '0;
   logic              clear_req = 1'b0;
   logic              clear_busy;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              lcd_busy = 1'b0;
   logic              refresh_start;

   int n_assert = 0;
   int n_fail   = 0;
   int n_writes = 0;
   logic [DATA_W-1:0] tb_ram [DEPTH];

   lcd_fb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .HOLDOFF(HOLDOFF)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .wr_valid0(wr_valid0), .wr_valid1(wr_valid1),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1),
      .clear_req(clear_req), .clear_busy(clear_busy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
      .lcd_busy(lcd_busy), .refresh_start(refresh_start)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed no end of test, expected finish within 1ms");
      $fatal(1, "watchdog expired");
   end

   // Stands in for the RAM itself and checks grant exclusivity every cycle.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         n_assert++;
         assert (!(gnt0 === 1'b1 && gnt1 === 1'b1)) else begin
            n_fail++;
            $error("FAIL gnt_exclusive: observed gnt0=%b gnt1=%b, expected at most one high", gnt0, gnt1);
         end
         if (ram_we === 1'b1) begin
            tb_ram[ram_addr] = ram_data;
            n_writes++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_clear_busy"}, clear_busy, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_refresh"}, refresh_start, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_data"}, ram_data, 0);
   endtask

   // Counts cycles from "now" until the pulse; the pulse must last exactly one cycle.
   task automatic wait_refresh(input string tag, input int exp_cyc);
      int seen = 0;
      for (int i = 1; i <= exp_cyc + 20; i++) begin
         step();
         if (refresh_start === 1'b1) begin
            seen = i;
            break;
         end
      end
      chk(tag, seen, exp_cyc);
      $display("[tb] refresh %s after %0d cycles", tag, seen);
      if (seen != 0) begin
         step();
         chk({tag, "_width"}, refresh_start, 0);
      end
   endtask

   int kind_q[$];
   int idx_q[$];
   int seg_kind[13] = '{K_G0, K_NONE, K_G1, K_NONE, K_G0, K_NONE, K_G1, K_NONE,
                        K_CLR, K_NONE, K_G0, K_NONE, K_G1};
   int seg_len[13]  = '{MAX_BURST, 1, MAX_BURST, 1, MAX_BURST, 1, MAX_BURST, 1,
                        DEPTH, 1, MAX_BURST, 1, 4};

   initial begin
      logic [ADDR_W-1:0] t2_addr [3];
      logic [DATA_W-1:0] t2_data [3];
      logic [DATA_W-1:0] keep_data;
      int pulses;
      int pk;
      int writes_at_rst;

      // Reset state, then the power-up refresh.
      repeat (3) step();
      chk_all_zero("reset");
      sys_rst = 1'b0;
      wait_refresh("refresh_after_reset", HOLDOFF + 1);

      lcd_busy = 1'b1;
      pulses = 0;
      repeat (100) begin
         step();
         if (refresh_start === 1'b1) pulses++;
      end
      chk("no_pulse_while_busy", pulses, 0);

      // Single requester, three beats while the LCD is still busy.
      t2_addr = '{10'd5, 10'd6, 10'd7};
      t2_data = '{8'hA1, 8'hA2, 8'hA3};
      req0 = 1'b1; wr_valid0 = 1'b1; wr_addr0 = t2_addr[0]; wr_data0 = t2_data[0];
      step();
      chk("t2_gnt0_up", gnt0, 1);
      chk("t2_valid_before_gnt_ignored", ram_we, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t2_we%0d", k), ram_we, 1);
         chk($sformatf("t2_addr%0d", k), ram_addr, t2_addr[k]);
         chk($sformatf("t2_data%0d", k), ram_data, t2_data[k]);
         $display("[tb] write beat %0d addr=%0d data=%0h", k, ram_addr, ram_data);
         if (k < 2) begin
            wr_addr0 = t2_addr[k+1];
            wr_data0 = t2_data[k+1];
         end else begin
            req0 = 1'b0; wr_valid0 = 1'b0; lcd_busy = 1'b0;
         end
      end
      step();
      chk("t2_gnt0_drop", gnt0, 0);
      chk("t2_we_drop", ram_we, 0);
      wait_refresh("refresh_after_busy_write", HOLDOFF + 1);
      lcd_busy = 1'b1; step(); lcd_busy = 1'b0; step();
      for (int k = 0; k < 3; k++)
         chk($sformatf("t2_ram%0d", k), tb_ram[t2_addr[k]], t2_data[k]);

      // Owner schedule for two saturating requesters with a clear injected mid-grant.
      kind_q.push_back(K_NONE);
      idx_q.push_back(0);
      for (int s = 0; s < 13; s++)
         for (int j = 0; j < seg_len[s]; j++) begin
            kind_q.push_back(seg_kind[s]);
            idx_q.push_back(j);
         end
      req0 = 1'b1; req1 = 1'b1; wr_valid0 = 1'b1; wr_valid1 = 1'b1;
      wr_addr0 = ADDR_W'($urandom); wr_data0 = DATA_W'($urandom);
      wr_addr1 = ADDR_W'($urandom); wr_data1 = DATA_W'($urandom);
      sys_rst = 1'b1; step(); sys_rst = 1'b0;
      $display("[tb] round-robin + clear run over %0d cycles", kind_q.size() - 1);
      for (int c = 1; c < kind_q.size(); c++) begin
         step();
         chk($sformatf("rr_gnt0@%0d", c), gnt0, kind_q[c] == K_G0);
         chk($sformatf("rr_gnt1@%0d", c), gnt1, kind_q[c] == K_G1);
         chk($sformatf("rr_clear_busy@%0d", c), clear_busy, kind_q[c] == K_CLR);
         pk = kind_q[c-1];
         chk($sformatf("rr_we@%0d", c), ram_we, pk != K_NONE);
         if (pk == K_G0) begin
            chk($sformatf("rr_addr@%0d", c), ram_addr, wr_addr0);
            chk($sformatf("rr_data@%0d", c), ram_data, wr_data0);
         end else if (pk == K_G1) begin
            chk($sformatf("rr_addr@%0d", c), ram_addr, wr_addr1);
            chk($sformatf("rr_data@%0d", c), ram_data, wr_data1);
         end else if (pk == K_CLR) begin
            chk($sformatf("clr_addr@%0d", c), ram_addr, idx_q[c-1]);
            chk($sformatf("clr_data@%0d", c), ram_data, 0);
         end
         // First pulse lands inside the second gnt1 burst, the second inside CLEAR.
         clear_req = (c == 56) || (c == 500);
         wr_addr0 = ADDR_W'($urandom); wr_data0 = DATA_W'($urandom);
         wr_addr1 = ADDR_W'($urandom); wr_data1 = DATA_W'($urandom);
      end

      // Reset in the middle of a clear leaves the tail of the RAM untouched.
      req0 = 1'b0; req1 = 1'b0; wr_valid0 = 1'b0; wr_valid1 = 1'b0; clear_req = 1'b0;
      sys_rst = 1'b1; step(); sys_rst = 1'b0;
      keep_data = DATA_W'($urandom_range(1, 255));
      req1 = 1'b1; wr_valid1 = 1'b1; wr_addr1 = 10'd301; wr_data1 = keep_data;
      step();
      chk("t6_gnt1", gnt1, 1);
      step();
      chk("t6_seed_addr", ram_addr, 301);
      req1 = 1'b0; wr_valid1 = 1'b0;
      step();
      clear_req = 1'b1;
      step();
      chk("t6_clear_not_yet", clear_busy, 0);
      clear_req = 1'b0;
      step();
      chk("t6_clear_busy", clear_busy, 1);
      repeat (301) step();
      chk("t6_mid_we", ram_we, 1);
      chk("t6_mid_addr", ram_addr, 300);
      sys_rst = 1'b1;
      step();
      chk_all_zero("t6_after_rst");
      writes_at_rst = n_writes;
      sys_rst = 1'b0;
      wait_refresh("refresh_after_midclear_reset", HOLDOFF + 1);
      chk("t6_no_writes_after_rst", n_writes, writes_at_rst);
      chk("t6_clear_idle", clear_busy, 0);
      chk("t6_ram300_zero", tb_ram[300], 0);
      chk("t6_ram301_kept", tb_ram[301], keep_data);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
